// File: rtl/sudoku_puzzle_server.sv
// Host-side puzzle server for the sudoku core: assembles 36-bit host rows into
// 324-bit puzzles, queues them for the core, and streams captured answers back as rows.
module sudoku_puzzle_server #(
  parameter int QDEPTH = 4,
  parameter int RDEPTH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             go,
  input  logic             in_row_valid,
  input  logic [35:0]      in_row_data,
  output logic             in_row_ready,
  output logic [323:0]     puzzle_in,
  output logic             puzzle_avail,
  input  logic             read_puzzle,
  input  logic [323:0]     puzzle_out,
  input  logic             done_puzzle,
  output logic             out_row_valid,
  output logic [35:0]      out_row_data,
  output logic             out_row_last,
  input  logic             out_row_ready,
  output logic [CNT_W-1:0] underflow_cnt,
  output logic             overflow,
  output logic [CNT_W-1:0] solved_cnt
);

  localparam int QAW = $clog2(QDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam logic [QAW:0] Q_FULL = (QAW+1)'(QDEPTH);
  localparam logic [RAW:0] R_FULL = (RAW+1)'(RDEPTH);

  // Rows 0..7 of the puzzle under assembly; row 8 goes straight into the queue.
  logic [323:36]    asm_r;
  logic [3:0]       lr_r;
  logic [323:0]     qmem_r [QDEPTH];
  logic [QAW-1:0]   qwr_ptr_r;
  logic [QAW-1:0]   qrd_ptr_r;
  logic [QAW:0]     qcount_r;
  logic [323:0]     rmem_r [RDEPTH];
  logic [RAW-1:0]   rwr_ptr_r;
  logic [RAW-1:0]   rrd_ptr_r;
  logic [RAW:0]     rcount_r;
  logic [3:0]       ur_r;
  logic [CNT_W-1:0] underflow_cnt_r;
  logic [CNT_W-1:0] solved_cnt_r;
  logic             overflow_r;
  logic             go_r;

  logic             row_accept_s;
  logic             push_s;
  logic             pop_s;
  logic             cap_s;
  logic             rpop_s;
  logic [323:0]     res_word_s;
  logic [35:0]      res_row_s;

  assign in_row_ready  = (qcount_r < Q_FULL);
  assign puzzle_avail  = (qcount_r != '0) && (rcount_r < R_FULL);
  assign out_row_valid = (rcount_r != '0);
  assign out_row_last  = (ur_r == 4'd8);
  assign underflow_cnt = underflow_cnt_r;
  assign solved_cnt    = solved_cnt_r;
  assign overflow      = overflow_r;
  assign go            = go_r;

  assign row_accept_s = in_row_valid && in_row_ready;
  assign push_s       = row_accept_s && (lr_r == 4'd8);
  assign pop_s        = read_puzzle && (qcount_r != '0);
  assign cap_s        = done_puzzle && (rcount_r < R_FULL);
  assign rpop_s       = out_row_valid && out_row_ready && (ur_r == 4'd8);
  assign res_word_s   = rmem_r[rrd_ptr_r];

  // Queue head presented to the core, zero when nothing is queued.
  always_comb begin
    if (qcount_r != '0) begin
      puzzle_in = qmem_r[qrd_ptr_r];
    end else begin
      puzzle_in = 324'd0;
    end
  end

  // Select the current result row for the host.
  always_comb begin
    case (ur_r)
      4'd0:    res_row_s = res_word_s[323:288];
      4'd1:    res_row_s = res_word_s[287:252];
      4'd2:    res_row_s = res_word_s[251:216];
      4'd3:    res_row_s = res_word_s[215:180];
      4'd4:    res_row_s = res_word_s[179:144];
      4'd5:    res_row_s = res_word_s[143:108];
      4'd6:    res_row_s = res_word_s[107:72];
      4'd7:    res_row_s = res_word_s[71:36];
      4'd8:    res_row_s = res_word_s[35:0];
      default: res_row_s = 36'd0;
    endcase
    if (rcount_r != '0) begin
      out_row_data = res_row_s;
    end else begin
      out_row_data = 36'd0;
    end
  end

  // Core enable follows the host run bit by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_r <= 1'b0;
    end else begin
      go_r <= run;
    end
  end

  // Row assembly: each accepted row lands in slot lr_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_r <= '0;
      lr_r  <= 4'd0;
    end else if (row_accept_s) begin
      case (lr_r)
        4'd0:    asm_r[323:288] <= in_row_data;
        4'd1:    asm_r[287:252] <= in_row_data;
        4'd2:    asm_r[251:216] <= in_row_data;
        4'd3:    asm_r[215:180] <= in_row_data;
        4'd4:    asm_r[179:144] <= in_row_data;
        4'd5:    asm_r[143:108] <= in_row_data;
        4'd6:    asm_r[107:72]  <= in_row_data;
        4'd7:    asm_r[71:36]   <= in_row_data;
        default: asm_r          <= asm_r;
      endcase
      lr_r <= (lr_r == 4'd8) ? 4'd0 : lr_r + 4'd1;
    end
  end

  // Puzzle queue storage; pointers alone define validity, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      qmem_r[qwr_ptr_r] <= {asm_r, in_row_data};
    end
  end

  // Puzzle queue pointers, occupancy and underflow statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qwr_ptr_r       <= '0;
      qrd_ptr_r       <= '0;
      qcount_r        <= '0;
      underflow_cnt_r <= '0;
    end else begin
      if (push_s) begin
        qwr_ptr_r <= qwr_ptr_r + QAW'(1);
      end
      if (pop_s) begin
        qrd_ptr_r <= qrd_ptr_r + QAW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   qcount_r <= qcount_r + (QAW+1)'(1);
        2'b01:   qcount_r <= qcount_r - (QAW+1)'(1);
        default: qcount_r <= qcount_r;
      endcase
      if (read_puzzle && (qcount_r == '0) && (underflow_cnt_r != {CNT_W{1'b1}})) begin
        underflow_cnt_r <= underflow_cnt_r + CNT_W'(1);
      end
    end
  end

  // Result buffer storage.
  always_ff @(posedge clk) begin
    if (cap_s) begin
      rmem_r[rwr_ptr_r] <= puzzle_out;
    end
  end

  // Result capture, row unloader and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rwr_ptr_r    <= '0;
      rrd_ptr_r    <= '0;
      rcount_r     <= '0;
      ur_r         <= 4'd0;
      solved_cnt_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      if (cap_s) begin
        rwr_ptr_r <= rwr_ptr_r + RAW'(1);
        if (solved_cnt_r != {CNT_W{1'b1}}) begin
          solved_cnt_r <= solved_cnt_r + CNT_W'(1);
        end
      end
      if (done_puzzle && (rcount_r == R_FULL)) begin
        overflow_r <= 1'b1;
      end
      if (out_row_valid && out_row_ready) begin
        ur_r <= (ur_r == 4'd8) ? 4'd0 : ur_r + 4'd1;
      end
      if (rpop_s) begin
        rrd_ptr_r <= rrd_ptr_r + RAW'(1);
      end
      case ({cap_s, rpop_s})
        2'b10:   rcount_r <= rcount_r + (RAW+1)'(1);
        2'b01:   rcount_r <= rcount_r - (RAW+1)'(1);
        default: rcount_r <= rcount_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_puzzle_server.sv
// Directed bench for sudoku_puzzle_server: the testbench drives the core handshake itself.
module tb_sudoku_puzzle_server;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic         go;
  logic         in_row_valid = 1'b0;
  logic [35:0]  in_row_data = 36'd0;
  logic         in_row_ready;
  logic [323:0] puzzle_in;
  logic         puzzle_avail;
  logic         read_puzzle = 1'b0;
  logic [323:0] puzzle_out = 324'd0;
  logic         done_puzzle = 1'b0;
  logic         out_row_valid;
  logic [35:0]  out_row_data;
  logic         out_row_last;
  logic         out_row_ready = 1'b0;
  logic [15:0]  underflow_cnt;
  logic         overflow;
  logic [15:0]  solved_cnt;

  int checks = 0;
  int errors = 0;

  logic [323:0] p1;

  sudoku_puzzle_server #(.QDEPTH(4), .RDEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .go(go),
    .in_row_valid(in_row_valid), .in_row_data(in_row_data), .in_row_ready(in_row_ready),
    .puzzle_in(puzzle_in), .puzzle_avail(puzzle_avail), .read_puzzle(read_puzzle),
    .puzzle_out(puzzle_out), .done_puzzle(done_puzzle),
    .out_row_valid(out_row_valid), .out_row_data(out_row_data), .out_row_last(out_row_last),
    .out_row_ready(out_row_ready), .underflow_cnt(underflow_cnt), .overflow(overflow),
    .solved_cnt(solved_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [323:0] obs, input logic [323:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [323:0] pz(input logic [3:0] k);
    return {81{k}};
  endfunction

  task automatic send_row(input logic [35:0] row);
    bit ok = 1'b0;
    in_row_valid = 1'b1;
    in_row_data  = row;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_row_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_row_valid = 1'b0;
    if (!ok) check("row_accept_timeout", 324'd0, 324'd1);
  endtask

  task automatic load_word(input logic [323:0] w);
    for (int r = 0; r < 9; r++) send_row(w[323-36*r -: 36]);
  endtask

  task automatic pulse_read();
    read_puzzle = 1'b1;
    tick();
    read_puzzle = 1'b0;
  endtask

  initial begin
    p1 = {36'h123456789, 36'h456789123, 36'h789123456,
          36'h234567891, 36'h567891234, 36'h891234567,
          36'h345678912, 36'h678912345, 36'h912345678};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_go", go, 1'b0);
    check("rst_ready", in_row_ready, 1'b1);
    check("rst_avail", puzzle_avail, 1'b0);
    check("rst_pin", puzzle_in, 324'd0);
    check("rst_ovalid", out_row_valid, 1'b0);
    check("rst_odata", out_row_data, 36'd0);
    check("rst_olast", out_row_last, 1'b0);
    check("rst_under", underflow_cnt, 16'd0);
    check("rst_solved", solved_cnt, 16'd0);
    check("rst_ovf", overflow, 1'b0);
    run = 1'b1;
    tick();
    check("go_follows_run", go, 1'b1);

    // Reads on an empty queue
    repeat (3) pulse_read();
    check("under_cnt", underflow_cnt, 16'd3);
    check("under_pin", puzzle_in, 324'd0);
    check("under_avail", puzzle_avail, 1'b0);
    check("under_ready", in_row_ready, 1'b1);

    // Single puzzle assembly
    load_word(p1);
    check("p1_pin", puzzle_in, p1);
    check("p1_avail", puzzle_avail, 1'b1);

    // Fill the queue and stall the fifth puzzle
    load_word(pz(4'h2));
    load_word(pz(4'h3));
    check("q3_ready", in_row_ready, 1'b1);
    load_word(pz(4'h4));
    check("qfull_ready", in_row_ready, 1'b0);
    in_row_valid = 1'b1;
    in_row_data  = {9{4'h5}};
    repeat (3) tick();
    check("stall_ready", in_row_ready, 1'b0);
    check("stall_head", puzzle_in, p1);
    pulse_read();
    check("after_pop_ready", in_row_ready, 1'b1);
    check("after_pop_head", puzzle_in, pz(4'h2));
    load_word(pz(4'h5));
    check("refull_ready", in_row_ready, 1'b0);
    pulse_read();
    check("head_p3", puzzle_in, pz(4'h3));
    pulse_read();
    check("head_p4", puzzle_in, pz(4'h4));
    pulse_read();
    check("head_p5", puzzle_in, pz(4'h5));
    check("under_unchanged", underflow_cnt, 16'd3);

    // One result streamed back
    out_row_ready = 1'b1;
    puzzle_out    = pz(4'h9);
    done_puzzle   = 1'b1;
    tick();
    done_puzzle   = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("res9_valid", out_row_valid, 1'b1);
      check("res9_data", out_row_data, 36'h999999999);
      check("res9_last", out_row_last, (i == 8) ? 1'b1 : 1'b0);
      @(posedge clk);
    end
    #1;
    check("res9_empty", out_row_valid, 1'b0);
    check("res9_solved", solved_cnt, 16'd1);

    // Result buffer full and overflow
    out_row_ready = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    load_word(p1);
    done_puzzle = 1'b1;
    for (int k = 0; k < 4; k++) begin
      puzzle_out = pz(4'(10 + k));
      tick();
    end
    done_puzzle = 1'b0;
    check("rfull_avail", puzzle_avail, 1'b0);
    check("rfull_solved", solved_cnt, 16'd4);
    check("rfull_ovf", overflow, 1'b0);
    check("rfull_row0", out_row_data, 36'hAAAAAAAAA);
    puzzle_out  = pz(4'hE);
    done_puzzle = 1'b1;
    tick();
    done_puzzle = 1'b0;
    check("ovf_set", overflow, 1'b1);
    check("ovf_solved", solved_cnt, 16'd4);
    out_row_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("drain_data", out_row_data, 36'hAAAAAAAAA);
      check("drain_last", out_row_last, (i == 8) ? 1'b1 : 1'b0);
      @(posedge clk);
    end
    #1 out_row_ready = 1'b0;
    check("drain_avail", puzzle_avail, 1'b1);
    check("drain_next", out_row_data, 36'hBBBBBBBBB);
    check("ovf_sticky", overflow, 1'b1);

    // Reset in the middle of an assembly
    for (int r = 0; r < 5; r++) send_row(36'hFEDCBA987);
    #1 rst = 1'b1;
    #1;
    check("midrst_go", go, 1'b0);
    #1 rst = 1'b0;
    check("midrst_ready", in_row_ready, 1'b1);
    check("midrst_avail", puzzle_avail, 1'b0);
    check("midrst_pin", puzzle_in, 324'd0);
    check("midrst_ovalid", out_row_valid, 1'b0);
    check("midrst_ovf", overflow, 1'b0);
    check("midrst_solved", solved_cnt, 16'd0);
    load_word(p1);
    check("reload_pin", puzzle_in, p1);
    check("reload_avail", puzzle_avail, 1'b1);
    check("reload_under", underflow_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sudoku_puzzle_server.md
Name: sudoku_puzzle_server

Overview:
- Host-side counterpart of the sudoku core's puzzle handshake.
- Accepts puzzles from a host one 36-bit row at a time and assembles them into 324-bit words.
- Queues the assembled puzzles, drives them onto the core's puzzle_in / puzzle_avail interface, and pops one per read_puzzle.
- Captures puzzle_out on every done_puzzle into a result buffer, then serialises each result back to the host as nine rows.

Parameters:
- QDEPTH, 4: puzzle queue entries (power of 2, ≥2).
- RDEPTH, 4: result buffer entries (power of 2, ≥2).
- CNT_W, 16: width of the status counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- run  in  1  host enable for the core
- go  out  1  run registered; drives the core's go
- in_row_valid  in  1  host row valid
- in_row_data  in  36  one puzzle row; cell col0 in bits [35:32] … col8 in bits [3:0]
- in_row_ready  out  1  row accepted when valid && ready
- puzzle_in  out  324  head of the puzzle queue, or 0 when the queue is empty
- puzzle_avail  out  1  queue not empty AND result buffer not full
- read_puzzle  in  1  core pops the queue head
- puzzle_out  in  324  core answer
- done_puzzle  in  1  core answer valid this cycle
- out_row_valid  out  1  result row valid
- out_row_data  out  36  result row, same cell layout as in_row_data
- out_row_last  out  1  high with row 8
- out_row_ready  in  1  host accepts the row
- underflow_cnt  out  CNT_W  pops attempted on an empty queue
- overflow  out  1  sticky: a done_puzzle arrived while the result buffer was full
- solved_cnt  out  CNT_W  results captured

Behaviour:
- Reset values: all outputs 0, all counters and pointers 0, row counters 0, overflow 0. Exception: in_row_ready, which is combinational, reads 1 after reset.
- Puzzle word layout: row r occupies bits [323-36r : 288-36r], so row 0 is the msb end.
- Loader (row counter LR, 0..8):
  - in_row_ready = (qcount < QDEPTH), combinational from registers.
  - Each accepted row is written into the assembly register at row slot LR, and LR increments.
  - On the accept with LR==8, the completed word (including the row being accepted) is pushed, qcount increments and LR wraps to 0.
  - The pushed puzzle appears on puzzle_in the next cycle if the queue was empty.
  - in_row_ready falling mid-puzzle stalls the loader; the partial assembly is held.
- Queue:
  - puzzle_in = qcount ? mem[rd_ptr] : 0.
  - puzzle_avail = (qcount != 0) && (rcount < RDEPTH). It depends only on registers, so there is no combinational loop through the core.
  - read_puzzle with qcount != 0: rd_ptr++, qcount--.
  - read_puzzle with qcount == 0: no pop, underflow_cnt++ (saturating). This is legal while the core primes its pipeline.
  - Push and pop in the same cycle: both take effect and qcount is unchanged.
- Result capture:
  - done_puzzle with rcount < RDEPTH: write puzzle_out to rmem[wr_ptr], wr_ptr++, rcount++, solved_cnt++ (saturating).
  - done_puzzle with rcount == RDEPTH: data dropped, overflow set to 1 until reset.
- Unloader (row counter UR, 0..8):
  - out_row_valid = (rcount != 0).
  - out_row_data = row UR of rmem[rd_ptr_r].
  - out_row_last = (UR == 8).
  - On valid && ready: UR++. When UR == 8, the entry pops, rcount-- and UR returns to 0.
  - Rows within a result are never interleaved with another result.
  - Capture and pop in the same cycle: both take effect.
  - First row is valid the cycle after a done_puzzle into an empty buffer.
- go = run delayed by one register.
- Asynchronous reset mid-operation discards partial assemblies, queued puzzles and unread results immediately.

Test Plan:
- Load one puzzle as rows 0x123456789, 0x456789123 … (9 accepts), with the core stub idle. Required: puzzle_in equals the concatenated 324-bit word the cycle after the 9th accept, and puzzle_avail=1.
- Load QDEPTH+1 puzzles with no reads. Required: in_row_ready drops after the 4th push. The 5th puzzle's row 0 is not accepted until one read_puzzle pulse, after which in_row_ready=1 on the next cycle.
- Pulse read_puzzle 3× with the queue empty. Required: underflow_cnt=3, puzzle_in=0, qcount stays 0.
- Pulse done_puzzle with puzzle_out = all 0x9 cells, out_row_ready=1. Required: out_row_valid the next cycle, nine rows of 0x999999999, out_row_last on the 9th, solved_cnt=1.
- Fill the result buffer (4 dones, out_row_ready=0). Required: puzzle_avail=0. A 5th done sets overflow=1 and solved_cnt stays 4; draining one result restores puzzle_avail (queue non-empty).
- Assert rst after 5 of 9 rows are accepted, then reload a full puzzle. Required: the new puzzle appears intact with no remnant rows, and underflow_cnt=0.
